// File: rtl/pipeline_ctrl_pkg.sv
// Shared constants for the pipeline stall/flush controller: FSM encodings,
// the RV32 opcodes that decide register-source usage, and a debug view struct.
package pipeline_ctrl_pkg;

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_FLUSH  = 2'd1;
    localparam logic [1:0] ST_FREEZE = 2'd2;

    localparam logic [6:0] OPC_NOP    = 7'b0000000;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef struct packed {
        logic [1:0] state;
        logic [1:0] ret_state;
        logic [1:0] fcnt;
    } ctrl_dbg_t;

    function automatic logic uses_rs1(input logic [6:0] opc);
        return !(opc == OPC_LUI || opc == OPC_AUIPC || opc == OPC_JAL);
    endfunction

    function automatic logic uses_rs2(input logic [6:0] opc);
        return (opc == OPC_BRANCH || opc == OPC_STORE || opc == OPC_OP);
    endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard inputs from ID/EX/DMEM and the stall/flush controls returned to the
// pipeline registers.
interface pipeline_ctrl_if;
    // All signals are plain levels sampled every cycle; there is no valid/ready
    // pairing. The controller answers within the same cycle it sees the inputs.
    logic [6:0] id_opcode;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic [4:0] ex_rd;
    logic       ex_reg_we;
    logic       ex_is_load;
    logic       ctrl_pc_src;
    logic       dmem_stall;
    logic       pc_stall;
    logic       if_id_stall;
    logic       id_ex_bubble;
    logic       ex_wb_stall;
    logic       ctrl_id_reg_flush;

    modport master (
        output id_opcode, id_rs1, id_rs2, ex_rd, ex_reg_we, ex_is_load,
               ctrl_pc_src, dmem_stall,
        input  pc_stall, if_id_stall, id_ex_bubble, ex_wb_stall, ctrl_id_reg_flush
    );

    modport slave (
        input  id_opcode, id_rs1, id_rs2, ex_rd, ex_reg_we, ex_is_load,
               ctrl_pc_src, dmem_stall,
        output pc_stall, if_id_stall, id_ex_bubble, ex_wb_stall, ctrl_id_reg_flush
    );
endinterface

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating event counter with synchronous clear; sticks at all-ones.
module pipeline_ctrl_sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (clr) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush sequencer: DMEM freeze > EX redirect > load-use interlock,
// with a RUN/FLUSH/FREEZE state machine and saturating perf counters.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    pipeline_ctrl_if.slave   bus,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output ctrl_dbg_t        dbg
);

    localparam logic [1:0] FLUSH_INIT = 2'(FLUSH_CYCLES);

    logic [1:0] state, state_nx;
    logic [1:0] ret_state, ret_nx;
    logic [1:0] fcnt, fcnt_nx;
    logic [1:0] eff_state;
    logic       flush_q, flush_nx;
    logic       load_use;
    logic       redirect;
    logic       pc_stall, if_id_stall, id_ex_bubble, ex_wb_stall;

    always_comb begin
        // While frozen, decisions are made as if still in the state we left.
        eff_state = (state == ST_FREEZE) ? ret_state : state;

        load_use = bus.ex_is_load && bus.ex_reg_we && (bus.ex_rd != 5'd0) &&
                   !flush_q && (bus.id_opcode != OPC_NOP) &&
                   (((bus.ex_rd == bus.id_rs1) && uses_rs1(bus.id_opcode)) ||
                    ((bus.ex_rd == bus.id_rs2) && uses_rs2(bus.id_opcode)));

        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        id_ex_bubble = 1'b0;
        ex_wb_stall  = 1'b0;
        redirect     = 1'b0;
        state_nx     = state;
        ret_nx       = ret_state;
        fcnt_nx      = fcnt;
        flush_nx     = flush_q;

        if (rst) begin
            state_nx = ST_RUN;
        end else if (bus.dmem_stall) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            ex_wb_stall = 1'b1;
            state_nx    = ST_FREEZE;
            if (state != ST_FREEZE) begin
                ret_nx = state;
            end
        end else if (bus.ctrl_pc_src) begin
            id_ex_bubble = 1'b1;
            redirect     = 1'b1;
            fcnt_nx      = FLUSH_INIT;
            state_nx     = ST_FLUSH;
            flush_nx     = 1'b1;
        end else if (eff_state == ST_FLUSH) begin
            fcnt_nx = (fcnt == 2'd0) ? 2'd0 : fcnt - 2'd1;
            if (fcnt_nx == 2'd0) begin
                state_nx = ST_RUN;
                flush_nx = 1'b0;
            end else begin
                state_nx = ST_FLUSH;
                flush_nx = 1'b1;
            end
        end else begin
            state_nx = ST_RUN;
            flush_nx = 1'b0;
            if (load_use) begin
                pc_stall     = 1'b1;
                if_id_stall  = 1'b1;
                id_ex_bubble = 1'b1;
            end
        end
    end

    // Flush is forced high for the first cycle after reset to kill IMEM garbage.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_RUN;
            ret_state <= ST_RUN;
            fcnt      <= 2'd0;
            flush_q   <= 1'b1;
        end else begin
            state     <= state_nx;
            ret_state <= ret_nx;
            fcnt      <= fcnt_nx;
            flush_q   <= flush_nx;
        end
    end

    assign bus.pc_stall          = pc_stall;
    assign bus.if_id_stall       = if_id_stall;
    assign bus.id_ex_bubble      = id_ex_bubble;
    assign bus.ex_wb_stall       = ex_wb_stall;
    assign bus.ctrl_id_reg_flush = flush_q;

    assign dbg.state     = state;
    assign dbg.ret_state = ret_state;
    assign dbg.fcnt      = fcnt;

    pipeline_ctrl_sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .clr   (rst),
        .en    (pc_stall),
        .count (stall_cnt)
    );

    pipeline_ctrl_sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .clr   (rst),
        .en    (redirect),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: dut_a uses FLUSH_CYCLES=2/CNT_W=32,
// dut_b uses FLUSH_CYCLES=1/CNT_W=4 for freeze-resume and saturation cases.
module tb_pipeline_ctrl;
    import pipeline_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipeline_ctrl_if bus_a ();
    pipeline_ctrl_if bus_b ();

    logic [31:0] stall_cnt_a, flush_cnt_a;
    logic [3:0]  stall_cnt_b, flush_cnt_b;
    ctrl_dbg_t   dbg_a, dbg_b;

    int total = 0;
    int bad   = 0;

    pipeline_ctrl #(.FLUSH_CYCLES(2), .CNT_W(32)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a),
        .stall_cnt(stall_cnt_a), .flush_cnt(flush_cnt_a), .dbg(dbg_a)
    );

    pipeline_ctrl #(.FLUSH_CYCLES(1), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b),
        .stall_cnt(stall_cnt_b), .flush_cnt(flush_cnt_b), .dbg(dbg_b)
    );

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic [6:0] opc, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [4:0] rd, input logic we, input logic ld,
                           input logic pcs, input logic dms);
        bus_a.id_opcode = opc; bus_a.id_rs1 = rs1; bus_a.id_rs2 = rs2;
        bus_a.ex_rd = rd; bus_a.ex_reg_we = we; bus_a.ex_is_load = ld;
        bus_a.ctrl_pc_src = pcs; bus_a.dmem_stall = dms;
    endtask

    task automatic drive_b(input logic [6:0] opc, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [4:0] rd, input logic we, input logic ld,
                           input logic pcs, input logic dms);
        bus_b.id_opcode = opc; bus_b.id_rs1 = rs1; bus_b.id_rs2 = rs2;
        bus_b.ex_rd = rd; bus_b.ex_reg_we = we; bus_b.ex_is_load = ld;
        bus_b.ctrl_pc_src = pcs; bus_b.dmem_stall = dms;
    endtask

    task automatic idle_all();
        drive_a(OPC_NOP, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive_b(OPC_NOP, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Leaves the bench in the first cycle after reset release.
    task automatic do_reset();
        idle_all();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        idle_all();
        rst = 1'b1;
        drive_a(OPC_OP, 5'd5, 5'd1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1);
        step();
        @(negedge clk);
        total++; if (bus_a.pc_stall !== 1'b0) begin bad++; $display("FAIL rst_pc_stall: got %b want 0", bus_a.pc_stall); end
        total++; if (bus_a.ex_wb_stall !== 1'b0) begin bad++; $display("FAIL rst_ex_wb_stall: got %b want 0", bus_a.ex_wb_stall); end
        total++; if (bus_a.id_ex_bubble !== 1'b0) begin bad++; $display("FAIL rst_bubble: got %b want 0", bus_a.id_ex_bubble); end
        total++; if (stall_cnt_a !== 32'd0) begin bad++; $display("FAIL rst_stall_cnt: got %0d want 0", stall_cnt_a); end
        total++; if (flush_cnt_a !== 32'd0) begin bad++; $display("FAIL rst_flush_cnt: got %0d want 0", flush_cnt_a); end
        step();
        rst = 1'b0;
        idle_all();
        @(negedge clk);
        total++; if (bus_a.ctrl_id_reg_flush !== 1'b1) begin bad++; $display("FAIL rst_flush_first: got %b want 1", bus_a.ctrl_id_reg_flush); end
        total++; if (dbg_a.state !== ST_RUN) begin bad++; $display("FAIL rst_state: got %0d want %0d", dbg_a.state, ST_RUN); end
        step();
        @(negedge clk);
        total++; if (bus_a.ctrl_id_reg_flush !== 1'b0) begin bad++; $display("FAIL rst_flush_second: got %b want 0", bus_a.ctrl_id_reg_flush); end
        step();
    endtask

    task automatic test_load_use();
        do_reset();
        step();
        // EX: LW x5 ; ID: ADD x6, x5, x1
        drive_a(OPC_OP, 5'd5, 5'd1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        total++; if (bus_a.pc_stall !== 1'b1) begin bad++; $display("FAIL lu_pc_stall: got %b want 1", bus_a.pc_stall); end
        total++; if (bus_a.if_id_stall !== 1'b1) begin bad++; $display("FAIL lu_if_id_stall: got %b want 1", bus_a.if_id_stall); end
        total++; if (bus_a.id_ex_bubble !== 1'b1) begin bad++; $display("FAIL lu_bubble: got %b want 1", bus_a.id_ex_bubble); end
        total++; if (bus_a.ex_wb_stall !== 1'b0) begin bad++; $display("FAIL lu_ex_wb_stall: got %b want 0", bus_a.ex_wb_stall); end
        step();
        idle_all();
        @(negedge clk);
        total++; if (bus_a.pc_stall !== 1'b0) begin bad++; $display("FAIL lu_release: got %b want 0", bus_a.pc_stall); end
        total++; if (stall_cnt_a !== 32'd1) begin bad++; $display("FAIL lu_stall_cnt1: got %0d want 1", stall_cnt_a); end
        step();
        // ex_rd = x0 never interlocks
        drive_a(OPC_OP, 5'd0, 5'd1, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        total++; if (bus_a.pc_stall !== 1'b0) begin bad++; $display("FAIL lu_x0: got %b want 0", bus_a.pc_stall); end
        step();
        // LUI x5 does not read rs1 even if the field matches
        drive_a(OPC_LUI, 5'd5, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        total++; if (bus_a.pc_stall !== 1'b0) begin bad++; $display("FAIL lu_lui: got %b want 0", bus_a.pc_stall); end
        step();
        // ADDI: rs2 field matches but I-type ignores rs2
        drive_a(7'b0010011, 5'd1, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        total++; if (bus_a.pc_stall !== 1'b0) begin bad++; $display("FAIL lu_addi_rs2: got %b want 0", bus_a.pc_stall); end
        step();
        // STORE reads rs2 -> interlock
        drive_a(OPC_STORE, 5'd1, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        total++; if (bus_a.id_ex_bubble !== 1'b1) begin bad++; $display("FAIL lu_store_rs2: got %b want 1", bus_a.id_ex_bubble); end
        step();
        // EX writes x5 but is not a load -> forwarding covers it
        drive_a(OPC_OP, 5'd5, 5'd1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        total++; if (bus_a.pc_stall !== 1'b0) begin bad++; $display("FAIL lu_not_load: got %b want 0", bus_a.pc_stall); end
        step();
        idle_all();
        @(negedge clk);
        total++; if (stall_cnt_a !== 32'd2) begin bad++; $display("FAIL lu_stall_cnt2: got %0d want 2", stall_cnt_a); end
        step();
    endtask

    task automatic test_redirect();
        do_reset();
        step();
        drive_a(OPC_OP, 5'd5, 5'd1, 5'd7, 1'b1, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        total++; if (bus_a.id_ex_bubble !== 1'b1) begin bad++; $display("FAIL rd_bubble: got %b want 1", bus_a.id_ex_bubble); end
        total++; if (bus_a.pc_stall !== 1'b0) begin bad++; $display("FAIL rd_pc_stall: got %b want 0", bus_a.pc_stall); end
        total++; if (bus_a.ctrl_id_reg_flush !== 1'b0) begin bad++; $display("FAIL rd_flush_pre: got %b want 0", bus_a.ctrl_id_reg_flush); end
        step();
        for (int i = 0; i < 2; i++) begin
            // load-use pattern in ID is wrong-path and must be ignored
            drive_a(OPC_OP, 5'd5, 5'd1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
            @(negedge clk);
            total++; if (bus_a.ctrl_id_reg_flush !== 1'b1) begin bad++; $display("FAIL rd_flush_c%0d: got %b want 1", i, bus_a.ctrl_id_reg_flush); end
            total++; if (bus_a.pc_stall !== 1'b0) begin bad++; $display("FAIL rd_gated_c%0d: got %b want 0", i, bus_a.pc_stall); end
            step();
        end
        idle_all();
        @(negedge clk);
        total++; if (bus_a.ctrl_id_reg_flush !== 1'b0) begin bad++; $display("FAIL rd_flush_end: got %b want 0", bus_a.ctrl_id_reg_flush); end
        total++; if (flush_cnt_a !== 32'd1) begin bad++; $display("FAIL rd_flush_cnt: got %0d want 1", flush_cnt_a); end
        total++; if (dbg_a.state !== ST_RUN) begin bad++; $display("FAIL rd_state: got %0d want %0d", dbg_a.state, ST_RUN); end
        step();
    endtask

    task automatic test_freeze_in_flush();
        do_reset();
        step();
        drive_b(OPC_NOP, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        total++; if (bus_b.id_ex_bubble !== 1'b1) begin bad++; $display("FAIL fz_redirect_bubble: got %b want 1", bus_b.id_ex_bubble); end
        step();
        for (int i = 0; i < 3; i++) begin
            // a redirect presented mid-freeze is ignored
            drive_b(OPC_NOP, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, (i == 1), 1'b1);
            @(negedge clk);
            total++; if ({bus_b.pc_stall, bus_b.if_id_stall, bus_b.ex_wb_stall} !== 3'b111) begin
                bad++; $display("FAIL fz_holds_c%0d: got %b want 111", i, {bus_b.pc_stall, bus_b.if_id_stall, bus_b.ex_wb_stall}); end
            total++; if (bus_b.id_ex_bubble !== 1'b0) begin bad++; $display("FAIL fz_bubble_c%0d: got %b want 0", i, bus_b.id_ex_bubble); end
            total++; if (bus_b.ctrl_id_reg_flush !== 1'b1) begin bad++; $display("FAIL fz_flush_c%0d: got %b want 1", i, bus_b.ctrl_id_reg_flush); end
            step();
        end
        idle_all();
        @(negedge clk);
        total++; if (bus_b.ctrl_id_reg_flush !== 1'b1) begin bad++; $display("FAIL fz_flush_resume: got %b want 1", bus_b.ctrl_id_reg_flush); end
        total++; if (bus_b.pc_stall !== 1'b0) begin bad++; $display("FAIL fz_released: got %b want 0", bus_b.pc_stall); end
        step();
        @(negedge clk);
        total++; if (bus_b.ctrl_id_reg_flush !== 1'b0) begin bad++; $display("FAIL fz_flush_end: got %b want 0", bus_b.ctrl_id_reg_flush); end
        total++; if (flush_cnt_b !== 4'd1) begin bad++; $display("FAIL fz_flush_cnt: got %0d want 1", flush_cnt_b); end
        total++; if (stall_cnt_b !== 4'd3) begin bad++; $display("FAIL fz_stall_cnt: got %0d want 3", stall_cnt_b); end
        step();
    endtask

    task automatic test_collision();
        do_reset();
        step();
        drive_a(OPC_OP, 5'd5, 5'd1, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        total++; if (bus_a.id_ex_bubble !== 1'b1) begin bad++; $display("FAIL col_bubble: got %b want 1", bus_a.id_ex_bubble); end
        total++; if (bus_a.pc_stall !== 1'b0) begin bad++; $display("FAIL col_pc_stall: got %b want 0", bus_a.pc_stall); end
        total++; if (bus_a.if_id_stall !== 1'b0) begin bad++; $display("FAIL col_if_id: got %b want 0", bus_a.if_id_stall); end
        step();
        idle_all();
        step();
        step();
        @(negedge clk);
        total++; if (bus_a.ctrl_id_reg_flush !== 1'b0) begin bad++; $display("FAIL col_flush_done: got %b want 0", bus_a.ctrl_id_reg_flush); end
        drive_a(OPC_OP, 5'd5, 5'd1, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1);
        #1;
        total++; if ({bus_a.pc_stall, bus_a.ex_wb_stall, bus_a.id_ex_bubble} !== 3'b110) begin
            bad++; $display("FAIL col_freeze: got %b want 110", {bus_a.pc_stall, bus_a.ex_wb_stall, bus_a.id_ex_bubble}); end
        step();
        idle_all();
        @(negedge clk);
        total++; if (flush_cnt_a !== 32'd1) begin bad++; $display("FAIL col_flush_cnt: got %0d want 1", flush_cnt_a); end
        total++; if (stall_cnt_a !== 32'd1) begin bad++; $display("FAIL col_stall_cnt: got %0d want 1", stall_cnt_a); end
        total++; if (bus_a.ctrl_id_reg_flush !== 1'b0) begin bad++; $display("FAIL col_flush_held: got %b want 0", bus_a.ctrl_id_reg_flush); end
        step();
    endtask

    task automatic test_reset_mid_flush();
        do_reset();
        step();
        drive_a(OPC_NOP, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        step();
        idle_all();
        @(negedge clk);
        total++; if (bus_a.ctrl_id_reg_flush !== 1'b1) begin bad++; $display("FAIL rmf_in_flush: got %b want 1", bus_a.ctrl_id_reg_flush); end
        step();
        rst = 1'b1;
        drive_a(OPC_NOP, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        total++; if (bus_a.id_ex_bubble !== 1'b0) begin bad++; $display("FAIL rmf_bubble_in_rst: got %b want 0", bus_a.id_ex_bubble); end
        step();
        rst = 1'b0;
        idle_all();
        @(negedge clk);
        total++; if (dbg_a.state !== ST_RUN) begin bad++; $display("FAIL rmf_state: got %0d want %0d", dbg_a.state, ST_RUN); end
        total++; if (flush_cnt_a !== 32'd0) begin bad++; $display("FAIL rmf_flush_cnt: got %0d want 0", flush_cnt_a); end
        total++; if (bus_a.ctrl_id_reg_flush !== 1'b1) begin bad++; $display("FAIL rmf_flush_first: got %b want 1", bus_a.ctrl_id_reg_flush); end
        step();
        @(negedge clk);
        total++; if (bus_a.ctrl_id_reg_flush !== 1'b0) begin bad++; $display("FAIL rmf_flush_second: got %b want 0", bus_a.ctrl_id_reg_flush); end
        step();
    endtask

    task automatic test_saturation();
        do_reset();
        step();
        for (int i = 0; i < 20; i++) begin
            drive_b(OPC_BRANCH, 5'd2, 5'd9, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0);
            step();
            idle_all();
            step();
            if (i == 14) begin
                total++; if (stall_cnt_b !== 4'd15) begin bad++; $display("FAIL sat_at15: got %0d want 15", stall_cnt_b); end
            end
        end
        @(negedge clk);
        total++; if (stall_cnt_b !== 4'd15) begin bad++; $display("FAIL sat_final: got %0d want 15", stall_cnt_b); end
        step();
    endtask

    initial begin
        idle_all();
        test_reset();
        test_load_use();
        test_redirect();
        test_freeze_in_flush();
        test_collision();
        test_reset_mid_flush();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
